// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that gives NUM_REQ requesters turns on one
// shared uart_tx. The current owner's start/data go through to the UART, and the
// UART busy goes back to the owner only. Ownership lasts for a session: it ends
// when the owner drops req, or when the owner holds the UART idle too long.
// NUM_REQ must be in the range 2..4 because owner is two bits wide.
module uart_tx_arbiter #(
    parameter int          NUM_REQ = 3,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   tx_start_in,
    input  logic [8*NUM_REQ-1:0] tx_data_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   tx_busy_out,
    output logic [1:0]           owner,
    output logic                 active,
    output logic                 timeout_pulse,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [19:0] TIMEOUT_LAST = TIMEOUT - 20'd1;
    localparam logic [1:0]  LAST_RESET   = 2'(NUM_REQ - 1);

    state_t               state, state_d;
    logic [NUM_REQ-1:0]   mask, mask_d;
    logic [19:0]          idle_cnt, idle_cnt_d;
    logic [1:0]           last_owner, last_owner_d;

    logic [NUM_REQ-1:0]   gnt_d, busy_d;
    logic [1:0]           owner_d;
    logic                 active_d, timeout_d, start_d;
    logic [7:0]           data_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;

    logic                 sel_req, sel_start;
    logic [7:0]           sel_data;

    // A requester that was timed out stays masked until it drops req.
    assign eligible = req & ~mask;

    // Select the owner's request, start and data byte from the packed inputs.
    always_comb begin
        sel_req   = 1'b0;
        sel_start = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 2'(i)) begin
                sel_req   = req[i];
                sel_start = tx_start_in[i];
                sel_data  = tx_data_in[8*i +: 8];
            end
        end
    end

    // Round-robin pick: search from the index after last_owner and wrap around.
    always_comb begin
        int idx;
        idx         = 0;
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. The outputs are computed here and
    // registered below, so every output changes only on a clock edge.
    always_comb begin
        state_d      = state;
        gnt_d        = gnt;
        owner_d      = owner;
        active_d     = active;
        timeout_d    = 1'b0;
        start_d      = 1'b0;
        data_d       = uart_tx_data;
        busy_d       = '0;
        mask_d       = mask & req;
        idle_cnt_d   = '0;
        last_owner_d = last_owner;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    gnt_d    = pick_onehot;
                    owner_d  = pick_idx;
                    active_d = 1'b1;
                end
            end

            GRANT: begin
                start_d = sel_start;
                data_d  = sel_data;
                busy_d  = gnt & {NUM_REQ{uart_tx_busy}};
                if (!sel_req) begin
                    state_d = DRAIN;
                end else if (!sel_start && !uart_tx_busy) begin
                    if (idle_cnt == TIMEOUT_LAST) begin
                        state_d   = DRAIN;
                        timeout_d = 1'b1;
                        mask_d    = mask_d | gnt;
                    end else begin
                        idle_cnt_d = idle_cnt + 20'd1;
                    end
                end
            end

            DRAIN: begin
                if (!uart_tx_busy && !uart_tx_start) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    owner_d      = '0;
                    active_d     = 1'b0;
                    last_owner_d = owner;
                end else begin
                    start_d = sel_start;
                    data_d  = sel_data;
                    busy_d  = gnt & {NUM_REQ{uart_tx_busy}};
                end
            end

            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                owner_d  = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered outputs and arbitration bookkeeping. Reset drops the UART start at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt           <= '0;
            owner         <= '0;
            active        <= 1'b0;
            timeout_pulse <= 1'b0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            tx_busy_out   <= '0;
            mask          <= '0;
            idle_cnt      <= '0;
            last_owner    <= LAST_RESET;
        end else begin
            gnt           <= gnt_d;
            owner         <= owner_d;
            active        <= active_d;
            timeout_pulse <= timeout_d;
            uart_tx_start <= start_d;
            uart_tx_data  <= data_d;
            tx_busy_out   <= busy_d;
            mask          <= mask_d;
            idle_cnt      <= idle_cnt_d;
            last_owner    <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=3, TIMEOUT=16). The bench queues the
// expected bytes and grant owners when it drives stimulus. It pops and compares
// them when the DUT raises uart_tx_start or a new grant.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   tx_start_in;
    logic [8*NUM_REQ-1:0] tx_data_in;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   tx_busy_out;
    logic [1:0]           owner;
    logic                 active;
    logic                 timeout_pulse;
    logic                 uart_tx_start;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_busy;

    int pass_count  = 0;
    int check_count = 0;

    logic [7:0] byte_q  [$];
    logic [1:0] owner_q [$];

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (20'd16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .tx_start_in   (tx_start_in),
        .tx_data_in    (tx_data_in),
        .gnt           (gnt),
        .tx_busy_out   (tx_busy_out),
        .owner         (owner),
        .active        (active),
        .timeout_pulse (timeout_pulse),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_busy  (uart_tx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] s, input logic [23:0] d, input logic b);
        req          = r;
        tx_start_in  = s;
        tx_data_in   = d;
        uart_tx_busy = b;
    endtask

    // Wait for the grant to drop to zero, then rise again, and compare it with the queued owner.
    task automatic waitGrant(input string tag);
        int n;
        logic [1:0] exp_owner;
        n = 0;
        while (gnt !== 3'b000 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle_gap"}, 32'(gnt === 3'b000), 32'd1);
        n = 0;
        while (gnt === 3'b000 && n < 20) begin
            tick();
            n++;
        end
        if (owner_q.size() > 0) exp_owner = owner_q.pop_front();
        else exp_owner = 2'd3;
        checkOutput({tag, "_owner"}, 32'(owner), 32'(exp_owner));
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(3'b001 << exp_owner));
        checkOutput({tag, "_active"}, 32'(active), 32'd1);
    endtask

    // Wait for the UART start, then compare the forwarded byte with the queued byte.
    task automatic waitStart(input string tag);
        int n;
        logic [7:0] exp_byte;
        n = 0;
        while (uart_tx_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput({tag, "_start"}, 32'(uart_tx_start), 32'd1);
        if (byte_q.size() > 0) exp_byte = byte_q.pop_front();
        else exp_byte = 8'hxx;
        checkOutput({tag, "_data"}, 32'(uart_tx_data), 32'(exp_byte));
    endtask

    // One complete byte from the current owner, then req drops and optionally comes straight back.
    task automatic runSession(input int idx, input logic [7:0] data, input logic reassert, input string tag);
        logic [2:0]  onehot;
        logic [23:0] d;
        onehot = 3'b001 << idx;
        d = tx_data_in;
        d[8*idx +: 8] = data;
        byte_q.push_back(data);
        applyStimulus(req, tx_start_in | onehot, d, 1'b0);
        waitStart(tag);
        applyStimulus(req, tx_start_in, tx_data_in, 1'b1);
        tick();
        checkOutput({tag, "_busy"}, 32'(tx_busy_out), 32'(onehot));
        tick();
        tick();
        applyStimulus(req, tx_start_in, tx_data_in, 1'b0);
        tick();
        checkOutput({tag, "_busy_fall"}, 32'(tx_busy_out), 32'd0);
        applyStimulus(req & ~onehot, tx_start_in & ~onehot, tx_data_in, 1'b0);
        tick();
        if (reassert) applyStimulus(req | onehot, tx_start_in, tx_data_in, 1'b0);
    endtask

    // Directed sequence covering reset, round-robin, drain, timeout, isolation and reset mid-byte.
    initial begin
        int n;
        rst_n = 1'b0;
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_owner", 32'(owner), 32'd0);
        checkOutput("reset_active", 32'(active), 32'd0);
        checkOutput("reset_timeout", 32'(timeout_pulse), 32'd0);
        checkOutput("reset_start", 32'(uart_tx_start), 32'd0);
        rst_n = 1'b1;
        tick();

        // First grant after reset goes to requester 0.
        applyStimulus(3'b001, 3'b000, 24'h0, 1'b0);
        tick();
        tick();
        checkOutput("first_gnt", 32'(gnt), 32'h1);
        checkOutput("first_owner", 32'(owner), 32'd0);
        checkOutput("first_active", 32'(active), 32'd1);

        // Round-robin with every requester holding req: order 0,1,2,0.
        applyStimulus(3'b111, 3'b000, 24'h0, 1'b0);
        owner_q.push_back(2'd1);
        owner_q.push_back(2'd2);
        owner_q.push_back(2'd0);
        runSession(0, 8'hA0, 1'b1, "rr0");
        waitGrant("rr_to1");
        runSession(1, 8'hA1, 1'b1, "rr1");
        waitGrant("rr_to2");
        runSession(2, 8'hA2, 1'b1, "rr2");
        waitGrant("rr_to0");

        // Owner 1 drops req while its byte is in flight, and the grant drains.
        runSession(0, 8'hA3, 1'b1, "pre_drain");
        owner_q.push_back(2'd1);
        waitGrant("drain_gnt1");
        byte_q.push_back(8'h41);
        applyStimulus(req, 3'b010, 24'h004100, 1'b0);
        waitStart("drain");
        applyStimulus(3'b101, 3'b010, 24'h004100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("drain_gnt_held", 32'(gnt), 32'h2);
            checkOutput("drain_data", 32'(uart_tx_data), 32'h41);
        end
        applyStimulus(3'b101, 3'b010, 24'h004100, 1'b0);
        tick();
        checkOutput("drain_busy_fall", 32'(tx_busy_out), 32'd0);
        applyStimulus(3'b101, 3'b000, 24'h004100, 1'b0);
        n = 0;
        while (gnt !== 3'b000 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drain_exit", 32'(gnt), 32'd0);
        checkOutput("drain_exit_data", 32'(uart_tx_data), 32'h41);
        checkOutput("drain_exit_start", 32'(uart_tx_start), 32'd0);
        checkOutput("drain_exit_active", 32'(active), 32'd0);

        // Owner 2 is mid-byte while requester 0 tries to start 8'h55.
        owner_q.push_back(2'd2);
        waitGrant("iso_gnt2");
        byte_q.push_back(8'hC2);
        applyStimulus(3'b101, 3'b100, 24'hC20000, 1'b0);
        waitStart("iso");
        applyStimulus(3'b101, 3'b101, 24'hC20055, 1'b1);
        tick();
        tick();
        checkOutput("iso_data", 32'(uart_tx_data), 32'hC2);
        checkOutput("iso_busy_out", 32'(tx_busy_out), 32'h4);
        checkOutput("iso_owner", 32'(owner), 32'd2);
        applyStimulus(3'b101, 3'b100, 24'hC20000, 1'b0);
        tick();
        applyStimulus(3'b001, 3'b000, 24'hC20000, 1'b0);
        owner_q.push_back(2'd0);
        waitGrant("iso_to0");

        // Owner 0 idles until the timeout, then it stays masked until req0 drops.
        applyStimulus(3'b101, 3'b000, 24'h0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("to_no_pulse_early", 32'(timeout_pulse), 32'd0);
        checkOutput("to_still_gnt", 32'(gnt), 32'h1);
        tick();
        checkOutput("to_pulse", 32'(timeout_pulse), 32'd1);
        checkOutput("to_pulse_gnt", 32'(gnt), 32'h1);
        tick();
        checkOutput("to_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
        checkOutput("to_released", 32'(gnt), 32'd0);
        owner_q.push_back(2'd2);
        waitGrant("to_gnt2");
        applyStimulus(3'b001, 3'b000, 24'h0, 1'b0);
        n = 0;
        while (gnt !== 3'b000 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("to_masked", 32'(gnt), 32'd0);
        end
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);
        tick();
        applyStimulus(3'b001, 3'b000, 24'h0, 1'b0);
        owner_q.push_back(2'd0);
        waitGrant("to_unmasked");

        // Reset while owner 0's byte start is active.
        byte_q.push_back(8'h77);
        applyStimulus(3'b111, 3'b001, 24'h000077, 1'b0);
        waitStart("rst_mid");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mid_owner", 32'(owner), 32'd0);
        checkOutput("rst_mid_active", 32'(active), 32'd0);
        checkOutput("rst_mid_start", 32'(uart_tx_start), 32'd0);
        checkOutput("rst_mid_busy_out", 32'(tx_busy_out), 32'd0);
        checkOutput("rst_mid_data", 32'(uart_tx_data), 32'd0);
        applyStimulus(3'b111, 3'b000, 24'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        owner_q.push_back(2'd0);
        waitGrant("post_reset");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 20'd1000000: idle-grant limit, in clk cycles.
REQ-003 Clocking: one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 Ports, in this order:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  NUM_REQ  per-requester session request, level; bit i = requester i.
tx_start_in  in  NUM_REQ  per-requester byte start, level, held until that requester sees busy fall.
tx_data_in  in  8*NUM_REQ  byte i occupies bits [8i+7:8i].
gnt  out  NUM_REQ  one-hot grant; all zero when no grant.
tx_busy_out  out  NUM_REQ  busy returned to each requester.
owner  out  2  index of the granted requester; 0 when no grant.
active  out  1  high in GRANT or DRAIN.
timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.
uart_tx_start  out  1  to the shared uart_tx.
uart_tx_data  out  8  to the shared uart_tx.
uart_tx_busy  in  1  from the shared uart_tx.

Function
REQ-005 FSM states SHALL be IDLE, GRANT and DRAIN; all outputs SHALL be registered.
REQ-006 IDLE, any eligible req bit set -> GRANT next cycle: gnt/owner = first eligible index after last_owner (round-robin, wrapping); active=1.
REQ-007 Eligible SHALL mean req[i]=1 and mask[i]=0.
REQ-008 GRANT: uart_tx_start <= tx_start_in[owner] and uart_tx_data <= tx_data_in[owner], one cycle latency.
REQ-009 GRANT: tx_busy_out[owner] <= uart_tx_busy; every non-owner bit SHALL be 0.
REQ-010 Non-granted tx_start_in bits SHALL be ignored; those requesters stall waiting for busy.
REQ-011 GRANT -> DRAIN when req[owner] falls.
REQ-012 DRAIN SHALL hold the pass-through of REQ-008/REQ-009 for owner, so a byte in flight completes.
REQ-013 DRAIN -> IDLE on the first cycle with uart_tx_busy=0 and uart_tx_start=0.
REQ-014 On DRAIN -> IDLE: gnt, owner, uart_tx_start and tx_busy_out SHALL clear; last_owner <= owner.
REQ-015 Idle counter (20 bits) SHALL increment in GRANT while tx_start_in[owner]=0 and uart_tx_busy=0, and clear otherwise.
REQ-016 Idle counter reaching TIMEOUT-1 -> DRAIN with timeout_pulse=1 for one cycle, and mask[owner] <= 1.
REQ-017 mask[i] SHALL clear on any cycle where req[i]=0.
REQ-018 Simultaneous req rise and DRAIN exit SHALL re-arbitrate in IDLE the next cycle; there is no IDLE bypass.
REQ-019 Re-grant needs at least one IDLE cycle; gnt SHALL never be multi-hot.
REQ-020 A requester that drops req then immediately reasserts it SHALL lose priority to other eligible requesters, per round-robin.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, gnt=0, owner=0, active=0, timeout_pulse=0.
REQ-022 rst_n low SHALL also clear uart_tx_start, uart_tx_data, tx_busy_out, mask and the idle counter, and set last_owner=NUM_REQ-1.
REQ-023 Reset mid-byte SHALL drop uart_tx_start at once; no further handshake with uart_tx is required.

Verification (TIMEOUT overridden to 16, NUM_REQ=3)
REQ-024 Reset release, req=3'b001 -> gnt=3'b001, owner=0, active=1 two cycles after req.
REQ-025 req=3'b111 held, each session sends one byte then drops req -> grant order 0,1,2,0.
REQ-026 Owner 1 sends 8'h41; req drops while uart_tx_busy=1 -> DRAIN; gnt held until busy falls; then IDLE; uart_tx_data=8'h41 throughout.
REQ-027 Owner 0 idles 16 cycles with req held -> timeout_pulse one cycle; req0 ignored until it drops; req2 granted next.
REQ-028 Owner 2 mid-byte, requester 0 asserts tx_start_in=1 with 8'h55 -> uart_tx_data unchanged; tx_busy_out[0]=0.
REQ-029 rst_n asserted in GRANT with uart_tx_start=1 -> all outputs zero in the same cycle; after release, round-robin restarts at index 0.
